vga_timing_ctrl: RTL
====================

# vga_timing_ctrl

Raster timing generator for the 640x480 @ 60 Hz VGA path. Divides the system clock down to a pixel-rate enable, runs the horizontal and vertical counters, and drives hsync/vsync to the monitor. Also supplies the hcount, vcount and bright signals consumed by the colour bit generators, which decide pixel colour from those values.

## Interface
- CLK_DIV, 2: system clocks per pixel (2 gives a 25 MHz pixel rate from a 50 MHz clock); legal range 1..16.
- H_SYNC, 96 / H_BACK, 48 / H_ACTIVE, 640 / H_FRONT, 16: horizontal segment lengths in pixels; H_TOTAL = sum = 800.
- V_SYNC, 2 / V_BACK, 33 / V_ACTIVE, 480 / V_FRONT, 10: vertical segment lengths in lines; V_TOTAL = sum = 525.
- clk  in  1  system clock; the block has one clock.
- rst_n  in  1  asynchronous, active-low reset.
- pix_en  out  1  one-clk pulse every CLK_DIV clocks; counters advance only on edges where pix_en is high.
- hcount  out  10  pixel index in line, 0..H_TOTAL-1.
- vcount  out  10  line index in frame, 0..V_TOTAL-1.
- hsync  out  1  active-low horizontal sync.
- vsync  out  1  active-low vertical sync.
- bright  out  1  high inside the active video window.
- frame_start  out  1  one-clk pulse on the clk where hcount=0 and vcount=0 are first presented.

## Operation
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pix_en is registered and is high for the one clk following div_cnt = CLK_DIV-1. When CLK_DIV = 1, pix_en is high every cycle after reset release.
- Horizontal counter: on each pix_en edge, hcount increments. It wraps from H_TOTAL-1 to 0.
- Vertical counter: vcount increments only on the pix_en edge where hcount wraps. It wraps from V_TOTAL-1 to 0 on that same edge.
- hsync = 0 iff hcount < H_SYNC (0..95).
- vsync = 0 iff vcount < V_SYNC (0..1).
- bright = 1 iff both conditions hold:
  - H_SYNC+H_BACK <= hcount < H_SYNC+H_BACK+H_ACTIVE (144..783);
  - V_SYNC+V_BACK <= vcount < V_SYNC+V_BACK+V_ACTIVE (35..514).
- hsync, vsync, bright and frame_start are registered and decoded from the next-state counter values. They are therefore always consistent with the hcount/vcount presented in the same clk, with zero skew.
- frame_start is high for exactly one clk per frame, on the clk after the edge where both counters wrap to 0. It is also high for one clk on the first pix_en after reset release.
- No other states exist. The block free-runs after reset and accepts no inputs other than clk and rst_n.

## Timing
- Reset (async assert, takes effect immediately, including mid-line or mid-frame): div_cnt=0, pix_en=0, hcount=0, vcount=0, hsync=0, vsync=0, bright=0, frame_start=0.
- First pix_en after reset release: high during the clk following the CLK_DIV-th rising edge after release.
- Counter latency: hcount changes on the edge on which pix_en is sampled high. Between pix_en pulses, every output holds its value.
- Line period = H_TOTAL*CLK_DIV clks (1600 at defaults).
- Frame period = V_TOTAL*H_TOTAL*CLK_DIV clks (840000 at defaults).
- Simultaneous wraps: hcount 799 -> 0 and vcount 524 -> 0 occur on the same edge. On the following clk, frame_start=1, hsync=0 and vsync=0.
- Widths: the counters are 10 bits. Parameter sums must be <= 1024; elaboration fails otherwise.

## Structure
- The shared package vga_pkg holds:
  - the default segment constants;
  - derived constants H_TOTAL, V_TOTAL, H_ACT_START, H_ACT_END, V_ACT_START, V_ACT_END;
  - the 10-bit count typedef shared with the bit generators.
- Sub-module pixel_tick_gen implements the CLK_DIV divider and the registered pix_en. The counter and sync decode stay in vga_timing_ctrl.

## Test plan
- Reset release, CLK_DIV=2 -> pix_en first high on the clk after the 2nd edge, then every 2nd clk; hcount steps 0,1,2 on successive pix_en pulses.
- Run one line -> hsync low for exactly 96 pixels (192 clks); hcount wraps 799 -> 0 and vcount increments 0 -> 1 on that edge.
- Active window -> bright first high at hcount=144, vcount=35; last high at hcount=783, vcount=514; never high when vcount<35 or vcount>=515.
- Full frame -> vsync low during lines 0..1 only; frame_start pulses once per 840000 clks, coincident with hcount=0, vcount=0.
- Assert rst_n low at hcount=500, vcount=300 -> all outputs 0 within the same cycle, asynchronously; after release, sequence restarts from 0,0 identically to the power-on case.
- CLK_DIV=1 -> pix_en constantly high after release; line period = 800 clks; decode boundaries unchanged.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the count type used by the timing generator
// and the colour bit generators.
package vga_pkg;

  localparam int CNT_W   = 10;
  localparam int CNT_MAX = 1 << CNT_W;

  typedef logic [CNT_W-1:0] count_t;

  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;

  localparam int H_TOTAL     = DEF_H_SYNC + DEF_H_BACK + DEF_H_ACTIVE + DEF_H_FRONT;
  localparam int V_TOTAL     = DEF_V_SYNC + DEF_V_BACK + DEF_V_ACTIVE + DEF_V_FRONT;
  localparam int H_ACT_START = DEF_H_SYNC + DEF_H_BACK;
  localparam int H_ACT_END   = H_ACT_START + DEF_H_ACTIVE;
  localparam int V_ACT_START = DEF_V_SYNC + DEF_V_BACK;
  localparam int V_ACT_END   = V_ACT_START + DEF_V_ACTIVE;

  // Half-open range test done in int so an end bound of 1024 still works.
  function automatic logic in_range(input count_t c, input int lo, input int hi);
    return (int'(c) >= lo) && (int'(c) < hi);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Divides the system clock to the pixel rate: o_tick is the combinational
// last-count flag, o_pix_en its registered one-clk pulse.
module pixel_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick,
  output logic o_pix_en
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  generate
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
      $error("pixel_tick_gen: CLK_DIV must be in 1..16");
    end
  endgenerate

  logic [DW-1:0] r_div_cnt;
  logic          r_pix_en;

  assign o_tick   = (r_div_cnt == LAST);
  assign o_pix_en = r_pix_en;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_cnt <= '0;
      r_pix_en  <= 1'b0;
    end else begin
      r_div_cnt <= o_tick ? '0 : r_div_cnt + 1'b1;
      r_pix_en  <= o_tick;
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// 640x480@60 raster timing: pixel-rate counters plus registered sync/bright
// decode taken from next-state counts so every output lines up with hcount/vcount.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  output logic   o_pix_en,
  output count_t o_hcount,
  output count_t o_vcount,
  output logic   o_hsync,
  output logic   o_vsync,
  output logic   o_bright,
  output logic   o_frame_start
);

  localparam int HT   = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int VT   = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HA_S = H_SYNC + H_BACK;
  localparam int HA_E = HA_S + H_ACTIVE;
  localparam int VA_S = V_SYNC + V_BACK;
  localparam int VA_E = VA_S + V_ACTIVE;
  localparam count_t H_LAST = count_t'(HT - 1);
  localparam count_t V_LAST = count_t'(VT - 1);

  generate
    if (HT > CNT_MAX || VT > CNT_MAX) begin : g_bad_total
      $error("vga_timing_ctrl: segment sums must not exceed 1024");
    end
  endgenerate

  logic   w_tick, w_pix_en;
  logic   w_h_wrap, w_v_wrap;
  count_t w_h_nxt, w_v_nxt;
  count_t r_hcount, r_vcount;
  logic   r_hsync, r_vsync, r_bright, r_frame_start, r_first;

  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .o_tick   (w_tick),
    .o_pix_en (w_pix_en)
  );

  always_comb begin
    w_h_wrap = (r_hcount == H_LAST);
    w_v_wrap = (r_vcount == V_LAST);
    w_h_nxt  = r_hcount;
    w_v_nxt  = r_vcount;
    if (w_pix_en) begin
      w_h_nxt = w_h_wrap ? '0 : r_hcount + 1'b1;
      if (w_h_wrap) w_v_nxt = w_v_wrap ? '0 : r_vcount + 1'b1;
    end
  end

  // r_first marks the frame that starts at reset, announced with the first pix_en.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_bright      <= 1'b0;
      r_frame_start <= 1'b0;
      r_first       <= 1'b1;
    end else begin
      r_hcount      <= w_h_nxt;
      r_vcount      <= w_v_nxt;
      r_hsync       <= !in_range(w_h_nxt, 0, H_SYNC);
      r_vsync       <= !in_range(w_v_nxt, 0, V_SYNC);
      r_bright      <= in_range(w_h_nxt, HA_S, HA_E) && in_range(w_v_nxt, VA_S, VA_E);
      r_frame_start <= (w_tick && r_first) || (w_pix_en && w_h_wrap && w_v_wrap);
      if (w_tick) r_first <= 1'b0;
    end
  end

  assign o_pix_en      = w_pix_en;
  assign o_hcount      = r_hcount;
  assign o_vcount      = r_vcount;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_bright      = r_bright;
  assign o_frame_start = r_frame_start;

endmodule
